// File: rtl/lb_reg_responder.sv
// rtl/lb_reg_responder.sv - local-bus register responder for the UDP bridge
//
// Purpose:
//   Target side of the bridge local bus. Decodes write strobes into a bank of
//   NCTRL 32b control registers, and returns read data from the control bank,
//   NSTAT read-only status inputs, a block ID, and a transaction counter. Each
//   read result appears on lb_rdata exactly READ_LAT cycles after its strobe.
//
// Address map (word addresses, lb_addr[23:6] must be zero):
//   0x00..0x0F  ctrl[k]   RW   (k < NCTRL)
//   0x10..0x1F  stat[k]   RO   (k < NSTAT)
//   0x20        BLOCK_ID  RO
//   0x21        txn_cnt   R: count of lb_valid strobes, W: clear
//   0x22        bad_cnt   RO   (only with LB_BADADDR_CNT_EN)
//   0x23        bad_cnt clear on write (only with LB_BADADDR_CNT_EN)
//   anything else reads UNMAPPED
//
// Optional feature macro: LB_BADADDR_CNT_EN
//   Adds a 16b saturating counter of strobes to unmapped addresses and writes
//   to read-only addresses.
//
// Ports:
//   lb_clk      local-bus clock
//   lb_rst_n    asynchronous active-low reset
//   lb_valid    one-cycle transaction strobe
//   lb_rnw      1 = read, 0 = write
//   lb_renable  read launch strobe (lb_valid & lb_rnw)
//   lb_addr     24b word address
//   lb_wdata    32b write data
//   lb_rdata    32b read data, holds until the next read result
//   ctrl_out    control registers, reg k at [32k+31:32k]
//   ctrl_wstb   one-cycle per-register pulse, aligned with new ctrl_out
//   stat_in     status words, stat k at [32k+31:32k]

module lb_reg_responder #(
   parameter int                  NCTRL     = 8,
   parameter int                  NSTAT     = 8,
   parameter int                  READ_LAT  = 3,
   parameter logic [NCTRL*32-1:0] CTRL_INIT = '0,
   parameter logic [31:0]         BLOCK_ID  = 32'h4C425231,
   parameter logic [31:0]         UNMAPPED  = 32'hDEADF00D
) (
   input  logic                  lb_clk,
   input  logic                  lb_rst_n,
   input  logic                  lb_valid,
   input  logic                  lb_rnw,
   input  logic                  lb_renable,
   input  logic [23:0]           lb_addr,
   input  logic [31:0]           lb_wdata,
   output logic [31:0]           lb_rdata,
   output logic [NCTRL*32-1:0]   ctrl_out,
   output logic [NCTRL-1:0]      ctrl_wstb,
   input  logic [NSTAT*32-1:0]   stat_in
);

   logic        wr_stb;
   logic        rd_stb;
   logic        hi_zero;
   logic [5:0]  low_addr;
   logic [3:0]  idx;
   logic        sel_ctrl;
   logic        sel_stat;
   logic        sel_id;
   logic        sel_cnt;
   logic        mapped;
   logic [31:0] rd_val;
   logic [31:0] txn_cnt;
   logic [31:0] ctrl_r [NCTRL];
   logic        fin_v;
   logic [31:0] fin_d;

`ifdef LB_BADADDR_CNT_EN
   logic        sel_bad;
   logic        sel_bad_clr;
   logic        bad_hit;
   logic [15:0] bad_cnt;
`endif

   // lb_renable alone is not a transaction; it must coincide with a read strobe
   assign wr_stb = lb_valid & ~lb_rnw;
   assign rd_stb = lb_valid & lb_rnw & lb_renable;

   // ---------------------------------------------------------------- decode
   assign hi_zero  = (lb_addr[23:6] == '0);
   assign low_addr = lb_addr[5:0];
   assign idx      = lb_addr[3:0];

   assign sel_ctrl = hi_zero && (low_addr[5:4] == 2'b00) && ({1'b0, idx} < 5'(NCTRL));
   assign sel_stat = hi_zero && (low_addr[5:4] == 2'b01) && ({1'b0, idx} < 5'(NSTAT));
   assign sel_id   = hi_zero && (low_addr == 6'h20);
   assign sel_cnt  = hi_zero && (low_addr == 6'h21);

`ifdef LB_BADADDR_CNT_EN
   assign sel_bad     = hi_zero && (low_addr == 6'h22);
   assign sel_bad_clr = hi_zero && (low_addr == 6'h23);
   assign mapped      = sel_ctrl | sel_stat | sel_id | sel_cnt | sel_bad | sel_bad_clr;
   // 0x22 is read-only but writes to it are deliberately not counted
   assign bad_hit     = lb_valid & (~mapped | (wr_stb & (sel_stat | sel_id)));
`else
   assign mapped      = sel_ctrl | sel_stat | sel_id | sel_cnt;
`endif

   // ------------------------------------------------------------- read mux
   always_comb begin
      rd_val = UNMAPPED;
      if (sel_ctrl) begin
         for (int k = 0; k < NCTRL; k++)
            if (idx == 4'(k)) rd_val = ctrl_r[k];
      end else if (sel_stat) begin
         for (int k = 0; k < NSTAT; k++)
            if (idx == 4'(k)) rd_val = stat_in[32*k +: 32];
      end else if (sel_id) begin
         rd_val = BLOCK_ID;
      end else if (sel_cnt) begin
         rd_val = txn_cnt;
`ifdef LB_BADADDR_CNT_EN
      end else if (sel_bad) begin
         rd_val = {16'h0, bad_cnt};
`endif
      end
      if (!mapped) rd_val = UNMAPPED;
   end

   // ------------------------------------------------------ control registers
   always_ff @(posedge lb_clk or negedge lb_rst_n) begin
      if (!lb_rst_n) begin
         for (int k = 0; k < NCTRL; k++) ctrl_r[k] <= CTRL_INIT[32*k +: 32];
         ctrl_wstb <= '0;
      end else begin
         for (int k = 0; k < NCTRL; k++) begin
            if (wr_stb && sel_ctrl && (idx == 4'(k))) begin
               ctrl_r[k]    <= lb_wdata;
               ctrl_wstb[k] <= 1'b1;
            end else begin
               ctrl_wstb[k] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < NCTRL; g++) begin : g_ctrl_out
      assign ctrl_out[32*g +: 32] = ctrl_r[g];
   end

   // ------------------------------------------------------- transaction count
   // The clearing write itself is not counted; a read sees the pre-increment value.
   always_ff @(posedge lb_clk or negedge lb_rst_n) begin
      if (!lb_rst_n) begin
         txn_cnt <= '0;
      end else if (lb_valid) begin
         if (wr_stb && sel_cnt) txn_cnt <= '0;
         else if (txn_cnt != '1) txn_cnt <= txn_cnt + 32'd1;
      end
   end

`ifdef LB_BADADDR_CNT_EN
   always_ff @(posedge lb_clk or negedge lb_rst_n) begin
      if (!lb_rst_n) begin
         bad_cnt <= '0;
      end else if (wr_stb && sel_bad_clr) begin
         bad_cnt <= '0;
      end else if (bad_hit && (bad_cnt != '1)) begin
         bad_cnt <= bad_cnt + 16'd1;
      end
   end
`endif

   // --------------------------------------------------------- read pipeline
   // The source is sampled on the strobe edge into stage 0; READ_LAT-1 shift
   // stages precede the lb_rdata hold register, so lb_rdata changes on the
   // READ_LAT-th edge counting the strobe edge.
   if (READ_LAT == 1) begin : g_lat1
      assign fin_v = rd_stb;
      assign fin_d = rd_val;
   end else begin : g_pipe
      logic [READ_LAT-2:0] v_q;
      logic [31:0]         d_q [READ_LAT-1];

      always_ff @(posedge lb_clk or negedge lb_rst_n) begin
         if (!lb_rst_n) begin
            v_q <= '0;
            for (int i = 0; i < READ_LAT-1; i++) d_q[i] <= '0;
         end else begin
            v_q[0] <= rd_stb;
            d_q[0] <= rd_val;
            for (int i = 1; i < READ_LAT-1; i++) begin
               v_q[i] <= v_q[i-1];
               d_q[i] <= d_q[i-1];
            end
         end
      end

      assign fin_v = v_q[READ_LAT-2];
      assign fin_d = d_q[READ_LAT-2];
   end

   always_ff @(posedge lb_clk or negedge lb_rst_n) begin
      if (!lb_rst_n)  lb_rdata <= '0;
      else if (fin_v) lb_rdata <= fin_d;
   end

endmodule
